frac_reduce: RTL and testbench

FRAC_REDUCE -- requirements
Module: frac_reduce

---
 rtl/frac_reduce.sv | 129 ++++++++++++
 tb/tb_frac_reduce.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/frac_reduce.sv
// frac_reduce: reduces an unsigned fraction num/den to lowest terms.
// A subtractive GCD phase finds g, then a repeated-subtraction phase
// divides both operands by g. A zero denominator short-circuits to DONE
// with err set. Valid/ready handshake on both sides; one fraction in flight.
module frac_reduce #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] num_out,
  output logic [WIDTH-1:0] den_out,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, GCD, DIV, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] n0, d0;   // captured operands
  logic [WIDTH-1:0] a, b;     // GCD working pair
  logic [WIDTH-1:0] g;        // gcd, always >= 1 once in DIV
  logic [WIDTH-1:0] rn, rd;   // division remainders
  logic [WIDTH-1:0] qn, qd;   // division quotients

  logic accept;
  logic gcd_done;
  logic div_done;

  assign accept   = in_valid & in_ready;
  assign gcd_done = (a == '0) || (b == '0);
  assign div_done = (rn < g) && (rd < g);

  // State register; reset wins over any simultaneous accept or drain.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = (den == '0) ? DONE : GCD;
      end
      GCD:  if (gcd_done) state_nxt = DIV;
      DIV:  if (div_done) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture, GCD by subtraction, division by subtraction, result.
  // Results stay in num_out/den_out/err until the next result overwrites them.
  always_ff @(posedge clk) begin
    if (rst) begin
      n0      <= '0;
      d0      <= '0;
      a       <= '0;
      b       <= '0;
      g       <= '0;
      rn      <= '0;
      rd      <= '0;
      qn      <= '0;
      qd      <= '0;
      num_out <= '0;
      den_out <= '0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            n0 <= num;
            d0 <= den;
            a  <= num;
            b  <= den;
            if (den == '0) begin
              num_out <= num;
              den_out <= '0;
              err     <= 1'b1;
            end
          end
        end
        GCD: begin
          if (gcd_done) begin
            // den is nonzero here, so at least one of a/b is nonzero: g >= 1
            g  <= (a == '0) ? b : a;
            rn <= n0;
            rd <= d0;
            qn <= '0;
            qd <= '0;
          end else if (a > b) begin
            a <= a - b;
          end else begin
            b <= b - a;
          end
        end
        DIV: begin
          if (rn >= g) begin
            rn <= rn - g;
            qn <= qn + 1'b1;
          end
          if (rd >= g) begin
            rd <= rd - g;
            qd <= qd + 1'b1;
          end
          if (div_done) begin
            num_out <= qn;
            den_out <= qd;
            err     <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_frac_reduce.sv
// tb_frac_reduce: directed table plus hand-written corner sequences and an
// exhaustive sweep checked against a Euclid-based reference reduction.
module tb_frac_reduce;

  localparam int W       = 4;
  localparam int LAT_MAX = (1 << (W + 1)) + 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] num, den;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] num_out, den_out;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  frac_reduce #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num       (num),
    .den       (den),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .num_out   (num_out),
    .den_out   (den_out),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [W-1:0] exp_num;
    logic [W-1:0] exp_den;
    logic         exp_err;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: Euclid by modulo, gcd(0,d)=d.
  function automatic void ref_reduce(input int n, input int d,
                                     output int rn, output int rd, output int re);
    int x, y, t;
    if (d == 0) begin
      rn = n; rd = 0; re = 1;
    end else begin
      x = n; y = d;
      while (y != 0) begin
        t = x % y; x = y; y = t;
      end
      rn = n / x; rd = d / x; re = 0;
    end
  endfunction

  // Runs one fraction with out_ready=1. Must be entered just after a negedge;
  // returns just after the negedge following the drain.
  task automatic xact(input logic [W-1:0] n, input logic [W-1:0] d,
                      output logic [W-1:0] on, output logic [W-1:0] od,
                      output logic oe, output int lat);
    num = n; den = d; in_valid = 1'b1;
    chk("in_ready_idle", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 3 * LAT_MAX);
    chk("out_valid_seen", int'(out_valid), 1);
    chk("in_ready_in_done", int'(in_ready), 0);
    on = num_out; od = den_out; oe = err;
    @(negedge clk);
    chk("in_ready_after_drain", int'(in_ready), 1);
    chk("out_valid_after_drain", int'(out_valid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[8];
    logic [W-1:0] on, od;
    logic         oe;
    int           lat;
    int           en, ed, ee;

    vecs[0] = '{num: 4'd8,  den: 4'd6, exp_num: 4'd4,  exp_den: 4'd3, exp_err: 1'b0};
    vecs[1] = '{num: 4'd15, den: 4'd7, exp_num: 4'd15, exp_den: 4'd7, exp_err: 1'b0};
    vecs[2] = '{num: 4'd0,  den: 4'd5, exp_num: 4'd0,  exp_den: 4'd1, exp_err: 1'b0};
    vecs[3] = '{num: 4'd6,  den: 4'd6, exp_num: 4'd1,  exp_den: 4'd1, exp_err: 1'b0};
    vecs[4] = '{num: 4'd12, den: 4'd4, exp_num: 4'd3,  exp_den: 4'd1, exp_err: 1'b0};
    vecs[5] = '{num: 4'd9,  den: 4'd0, exp_num: 4'd9,  exp_den: 4'd0, exp_err: 1'b1};
    vecs[6] = '{num: 4'd10, den: 4'd4, exp_num: 4'd5,  exp_den: 4'd2, exp_err: 1'b0};
    vecs[7] = '{num: 4'd15, den: 4'd1, exp_num: 4'd15, exp_den: 4'd1, exp_err: 1'b0};

    // Reset with a competing accept present: reset must win.
    rst = 1'b1; in_valid = 1'b1; num = 4'd9; den = 4'd0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_num_out", int'(num_out), 0);
    chk("rst_den_out", int'(den_out), 0);
    chk("rst_err", int'(err), 0);
    rst = 1'b0; in_valid = 1'b0;

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      xact(vecs[i].num, vecs[i].den, on, od, oe, lat);
      chk($sformatf("vec%0d_num", i), int'(on), int'(vecs[i].exp_num));
      chk($sformatf("vec%0d_den", i), int'(od), int'(vecs[i].exp_den));
      chk($sformatf("vec%0d_err", i), int'(oe), int'(vecs[i].exp_err));
      if (vecs[i].exp_err) chk($sformatf("vec%0d_divzero_lat", i), int'(lat <= 2), 1);
      else                 chk($sformatf("vec%0d_lat", i), int'(lat <= LAT_MAX), 1);
    end

    // Backpressure: 10/4 held for 5 cycles while in_valid pulses are ignored.
    out_ready = 1'b0;
    num = 4'd10; den = 4'd4; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 3 * LAT_MAX);
    chk("bp_out_valid_seen", int'(out_valid), 1);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0]; num = 4'd3; den = 4'd1;
      @(negedge clk);
      chk("bp_hold_valid", int'(out_valid), 1);
      chk("bp_hold_num", int'(num_out), 5);
      chk("bp_hold_den", int'(den_out), 2);
      chk("bp_hold_err", int'(err), 0);
      chk("bp_hold_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_out_valid", int'(out_valid), 0);
    chk("bp_drain_in_ready", int'(in_ready), 1);
    chk("bp_drain_num_kept", int'(num_out), 5);

    // Reset during DIV of 15/1 discards it; then 8/6 on the first free edge.
    num = 4'd15; den = 4'd1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_busy_in_ready", int'(in_ready), 0);
    chk("midrst_no_valid_pre", int'(out_valid), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", int'(in_ready), 1);
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_num_out_clr", int'(num_out), 0);
    xact(4'd8, 4'd6, on, od, oe, lat);
    chk("midrst_next_num", int'(on), 4);
    chk("midrst_next_den", int'(od), 3);
    chk("midrst_next_err", int'(oe), 0);

    // Exhaustive sweep, back-to-back.
    for (int n = 0; n < 16; n++) begin
      for (int d = 0; d < 16; d++) begin
        ref_reduce(n, d, en, ed, ee);
        xact(W'(n), W'(d), on, od, oe, lat);
        chk($sformatf("ex_%0d_%0d_num", n, d), int'(on), en);
        chk($sformatf("ex_%0d_%0d_den", n, d), int'(od), ed);
        chk($sformatf("ex_%0d_%0d_err", n, d), int'(oe), ee);
        chk($sformatf("ex_%0d_%0d_lat", n, d), int'(lat <= LAT_MAX), 1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
